// File: rtl/riscv_soft_bypass_unit_if.sv
// Bundle between the EX-stage pipeline and the ALU operand bypass unit.
// master = pipeline side (drives EX info, consumes forwards/writeback); slave = bypass unit.
interface riscv_soft_bypass_unit_if #(
  parameter int XPR_LEN = 32,
  parameter int REG_AW  = 5
);
  logic               pipe_stall;
  logic               ex_valid;
  logic               ex_wen;
  logic [REG_AW-1:0]  ex_waddr;
  logic               ex_is_load;
  logic [XPR_LEN-1:0] ex_result;
  logic [REG_AW-1:0]  ex_rs1;
  logic [REG_AW-1:0]  ex_rs2;
  logic               ex_rs1_used;
  logic               ex_rs2_used;
  logic [XPR_LEN-1:0] dmem_rdata;
  logic               fwd_a;
  logic [XPR_LEN-1:0] bypass_data_a;
  logic               fwd_b;
  logic [XPR_LEN-1:0] bypass_data_b;
  logic               load_use_stall;
  logic               wb_wen;
  logic [REG_AW-1:0]  wb_waddr;
  logic [XPR_LEN-1:0] wb_wdata;

  modport master (
    output pipe_stall, ex_valid, ex_wen, ex_waddr, ex_is_load, ex_result,
           ex_rs1, ex_rs2, ex_rs1_used, ex_rs2_used, dmem_rdata,
    input  fwd_a, bypass_data_a, fwd_b, bypass_data_b, load_use_stall,
           wb_wen, wb_waddr, wb_wdata
  );

  modport slave (
    input  pipe_stall, ex_valid, ex_wen, ex_waddr, ex_is_load, ex_result,
           ex_rs1, ex_rs2, ex_rs1_used, ex_rs2_used, dmem_rdata,
    output fwd_a, bypass_data_a, fwd_b, bypass_data_b, load_use_stall,
           wb_wen, wb_waddr, wb_wdata
  );
endinterface

// File: rtl/riscv_soft_bypass_unit.sv
// ALU operand bypass: owns the MEM/WB destination records, forwards the youngest
// live producer to each EX operand, and flags load-use hazards.
module riscv_soft_bypass_unit #(
  parameter int XPR_LEN = 32,
  parameter int REG_AW  = 5
) (
  input logic                     clk,
  input logic                     reset,
  riscv_soft_bypass_unit_if.slave bus
);

  localparam logic [REG_AW-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic               v;
    logic               wen;
    logic [REG_AW-1:0]  waddr;
    logic               is_load;
    logic [XPR_LEN-1:0] data;
  } mem_rec_t;

  typedef struct packed {
    logic               v;
    logic               wen;
    logic [REG_AW-1:0]  waddr;
    logic [XPR_LEN-1:0] data;
  } wb_rec_t;

  mem_rec_t mem_rec;
  wb_rec_t  wb_rec;

  logic mem_live;
  logic wb_live;
  logic load_hit_a;
  logic load_hit_b;
  logic stall;
  logic blocked_a;
  logic blocked_b;
  logic [XPR_LEN:0] res_a;
  logic [XPR_LEN:0] res_b;

  assign mem_live = mem_rec.v && mem_rec.wen && (mem_rec.waddr != ZERO_REG);
  assign wb_live  = wb_rec.v && wb_rec.wen && (wb_rec.waddr != ZERO_REG);

  // A live MEM record never targets x0, so an address match already implies rs != 0.
  assign load_hit_a = bus.ex_rs1_used && mem_live && mem_rec.is_load && (bus.ex_rs1 == mem_rec.waddr);
  assign load_hit_b = bus.ex_rs2_used && mem_live && mem_rec.is_load && (bus.ex_rs2 == mem_rec.waddr);
  assign stall      = bus.ex_valid && (load_hit_a || load_hit_b);
  assign blocked_a  = stall && load_hit_a;
  assign blocked_b  = stall && load_hit_b;

  // Returns {fwd, data}; an operand waiting on a load in MEM must not pick up a stale WB value.
  function automatic logic [XPR_LEN:0] resolve(input logic              used,
                                               input logic [REG_AW-1:0] rs,
                                               input logic              blocked);
    logic [XPR_LEN:0] r;
    r = '0;
    if (used && (rs != ZERO_REG)) begin
      if (mem_live && (mem_rec.waddr == rs) && !mem_rec.is_load) begin
        r = {1'b1, mem_rec.data};
      end else if (!blocked && wb_live && (wb_rec.waddr == rs)) begin
        r = {1'b1, wb_rec.data};
      end
    end
    return r;
  endfunction

  always_comb begin
    res_a = resolve(bus.ex_rs1_used, bus.ex_rs1, blocked_a);
    res_b = resolve(bus.ex_rs2_used, bus.ex_rs2, blocked_b);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_rec <= '0;
      wb_rec  <= '0;
    end else if (!bus.pipe_stall) begin
      wb_rec.v     <= mem_rec.v;
      wb_rec.wen   <= mem_rec.wen;
      wb_rec.waddr <= mem_rec.waddr;
      wb_rec.data  <= mem_rec.is_load ? bus.dmem_rdata : mem_rec.data;
      if (stall) begin
        mem_rec <= '0;
      end else begin
        mem_rec <= {bus.ex_valid, bus.ex_wen, bus.ex_waddr, bus.ex_is_load, bus.ex_result};
      end
    end
  end

  assign bus.fwd_a          = res_a[XPR_LEN];
  assign bus.bypass_data_a  = res_a[XPR_LEN-1:0];
  assign bus.fwd_b          = res_b[XPR_LEN];
  assign bus.bypass_data_b  = res_b[XPR_LEN-1:0];
  assign bus.load_use_stall = stall;
  assign bus.wb_wen         = wb_live;
  assign bus.wb_waddr       = wb_rec.waddr;
  assign bus.wb_wdata       = wb_rec.data;

endmodule

// File: tb/tb_riscv_soft_bypass_unit.sv
// Directed bench for the operand bypass unit: forwarding priority, x0, load-use, freeze, reset.
module tb_riscv_soft_bypass_unit;

  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;

  riscv_soft_bypass_unit_if #(.XPR_LEN(32), .REG_AW(5)) bus ();

  riscv_soft_bypass_unit #(.XPR_LEN(32), .REG_AW(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic v, input logic wen, input logic [4:0] waddr,
                        input logic ld, input logic [31:0] res,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2);
    bus.ex_valid    = v;
    bus.ex_wen      = wen;
    bus.ex_waddr    = waddr;
    bus.ex_is_load  = ld;
    bus.ex_result   = res;
    bus.ex_rs1      = rs1;
    bus.ex_rs2      = rs2;
    bus.ex_rs1_used = u1;
    bus.ex_rs2_used = u2;
    #1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset          = 1'b1;
    bus.pipe_stall = 1'b0;
    bus.dmem_rdata = '0;
    set_ex(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    reset = 1'b0;

    check_val("rst_fwd_a", bus.fwd_a, 0);
    check_val("rst_data_a", bus.bypass_data_a, 0);
    check_val("rst_fwd_b", bus.fwd_b, 0);
    check_val("rst_stall", bus.load_use_stall, 0);
    check_val("rst_wb_wen", bus.wb_wen, 0);
    check_val("rst_wb_wdata", bus.wb_wdata, 0);

    // single producer, then consumer through MEM then WB
    set_ex(1, 1, 5, 0, 32'h11, 0, 0, 0, 0);
    step();
    set_ex(1, 0, 0, 0, 0, 5, 6, 1, 1);
    check_val("t1_fwd_a", bus.fwd_a, 1);
    check_val("t1_data_a", bus.bypass_data_a, 32'h11);
    check_val("t1_fwd_b", bus.fwd_b, 0);
    check_val("t1_data_b", bus.bypass_data_b, 0);
    step();
    check_val("t1_wb_wen", bus.wb_wen, 1);
    check_val("t1_wb_waddr", bus.wb_waddr, 5);
    check_val("t1_wb_wdata", bus.wb_wdata, 32'h11);
    check_val("t1_wb_fwd_a", bus.bypass_data_a, 32'h11);

    // back-to-back writes to x5: MEM wins over WB
    set_ex(1, 1, 5, 0, 32'h11, 0, 0, 0, 0);
    step();
    set_ex(1, 1, 5, 0, 32'h22, 0, 0, 0, 0);
    step();
    set_ex(1, 0, 0, 0, 0, 5, 5, 1, 1);
    check_val("t2_data_a", bus.bypass_data_a, 32'h22);
    check_val("t2_data_b", bus.bypass_data_b, 32'h22);
    check_val("t2_wb_wdata", bus.wb_wdata, 32'h11);
    set_ex(1, 0, 0, 0, 0, 5, 5, 0, 1);
    check_val("t2_unused_a", bus.fwd_a, 0);
    step();

    // load-use on rs2=x7, with an older x7 value sitting in WB
    set_ex(1, 1, 7, 0, 32'h77, 0, 0, 0, 0);
    step();
    set_ex(1, 1, 7, 1, 32'h1000, 0, 0, 0, 0);
    step();
    bus.dmem_rdata = 32'hDEAD;
    set_ex(1, 0, 0, 0, 0, 0, 7, 0, 1);
    check_val("t3_stall", bus.load_use_stall, 1);
    check_val("t3_fwd_b_blocked", bus.fwd_b, 0);
    check_val("t3_data_b_blocked", bus.bypass_data_b, 0);
    check_val("t3_wb_old", bus.wb_wdata, 32'h77);
    bus.ex_valid = 1'b0;
    #1;
    check_val("t3_stall_bubble", bus.load_use_stall, 0);
    bus.ex_valid = 1'b1;
    #1;
    step();
    bus.dmem_rdata = 32'h0;
    #1;
    check_val("t3_stall_clear", bus.load_use_stall, 0);
    check_val("t3_fwd_b", bus.fwd_b, 1);
    check_val("t3_data_b", bus.bypass_data_b, 32'hDEAD);
    check_val("t3_wb_wdata", bus.wb_wdata, 32'hDEAD);

    // x0 is never forwarded or written
    set_ex(1, 1, 0, 0, 32'h55, 0, 0, 0, 0);
    step();
    set_ex(1, 0, 0, 0, 0, 0, 0, 1, 1);
    check_val("t4_fwd_a", bus.fwd_a, 0);
    check_val("t4_fwd_b", bus.fwd_b, 0);
    step();
    check_val("t4_wb_wen", bus.wb_wen, 0);

    // load-use frozen by pipe_stall for 3 cycles
    set_ex(1, 1, 9, 1, 32'h2000, 0, 0, 0, 0);
    step();
    bus.dmem_rdata = 32'hBEEF;
    bus.pipe_stall = 1'b1;
    set_ex(1, 0, 0, 0, 0, 9, 0, 1, 0);
    check_val("t5_stall_c0", bus.load_use_stall, 1);
    for (int i = 1; i <= 2; i++) begin
      step();
      check_val($sformatf("t5_stall_c%0d", i), bus.load_use_stall, 1);
      check_val($sformatf("t5_fwd_a_c%0d", i), bus.fwd_a, 0);
      check_val($sformatf("t5_wb_hold_c%0d", i), bus.wb_wen, 0);
    end
    step();
    bus.pipe_stall = 1'b0;
    #1;
    check_val("t5_stall_release", bus.load_use_stall, 1);
    check_val("t5_wb_hold_release", bus.wb_wen, 0);
    step();
    check_val("t5_stall_clear", bus.load_use_stall, 0);
    check_val("t5_fwd_a", bus.fwd_a, 1);
    check_val("t5_data_a", bus.bypass_data_a, 32'hBEEF);
    check_val("t5_wb_waddr", bus.wb_waddr, 9);

    // reset with live records and a pending load-use
    set_ex(1, 1, 3, 0, 32'h33, 0, 0, 0, 0);
    step();
    set_ex(1, 1, 4, 1, 32'h44, 0, 0, 0, 0);
    step();
    set_ex(1, 0, 0, 0, 0, 3, 4, 1, 1);
    check_val("t6_pre_fwd_a", bus.bypass_data_a, 32'h33);
    check_val("t6_pre_stall", bus.load_use_stall, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    check_val("t6_fwd_a", bus.fwd_a, 0);
    check_val("t6_fwd_b", bus.fwd_b, 0);
    check_val("t6_stall", bus.load_use_stall, 0);
    check_val("t6_wb_wen", bus.wb_wen, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
